// File: rtl/axis_i2c_cmd_seq_if.sv
// AXI-Stream command channel between the command sequencer and the I2C
// path input FIFO. The master drives data/valid, the slave drives ready.
interface axis_i2c_cmd_seq_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_i2c_cmd_seq.sv
// Programmable I2C command sequencer. A small table of command words is
// loaded while idle, then walked on start: DATA words are emitted as
// AXI-Stream beats, DELAY words stall for N*DELAY_UNIT cycles, and an
// all-ones word (or the last table slot) ends the run.
module axis_i2c_cmd_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int TABLE_DEPTH = 32,
    parameter int DELAY_UNIT  = 1000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cfg_we_i,
    input  logic [$clog2(TABLE_DEPTH)-1:0]   cfg_addr_i,
    input  logic [DATA_WIDTH-1:0]            cfg_wdata_i,
    input  logic                             start_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [$clog2(TABLE_DEPTH+1)-1:0] sent_cnt_o,
    axis_i2c_cmd_seq_if.master               m_axis
);
    localparam int AW = $clog2(TABLE_DEPTH);
    localparam int SW = $clog2(TABLE_DEPTH + 1);
    // Wide enough for 255 * DELAY_UNIT without overflow.
    localparam int CW = 8 + $clog2(DELAY_UNIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_DECODE = 3'd2,
        ST_SEND   = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

    // All-ones word terminates the table.
    function automatic logic is_end_f(input logic [DATA_WIDTH-1:0] w);
        return &w;
    endfunction

    // Opcode 0xFF with a non-all-ones word is a delay of w[7:0] ticks.
    function automatic logic is_delay_f(input logic [DATA_WIDTH-1:0] w);
        return (w[DATA_WIDTH-1 -: 8] == 8'hFF) && !(&w);
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [TABLE_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    state_t                state_r,  state_nxt_s;
    logic [AW-1:0]         ptr_r,    ptr_nxt_s;
    logic [CW-1:0]         cnt_r,    cnt_nxt_s;
    logic [DATA_WIDTH-1:0] tdata_r,  tdata_nxt_s;
    logic                  tvalid_r, tvalid_nxt_s;
    logic                  busy_r,   busy_nxt_s;
    logic                  done_r,   done_nxt_s;
    logic [SW-1:0]         sent_r,   sent_nxt_s;
    logic                  advance_s;
    logic                  finish_s;
    logic [CW-1:0]         delay_load_s;

    assign delay_load_s = CW'(rdata_r[7:0]) * CW'(DELAY_UNIT);

    // Command table: writes only while idle, registered read in READ state.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i && !busy_r) begin
            mem_r[cfg_addr_i] <= cfg_wdata_i;
        end
        if (state_r == ST_READ) begin
            rdata_r <= mem_r[ptr_r];
        end
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            ptr_r    <= '0;
            cnt_r    <= '0;
            tdata_r  <= '0;
            tvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sent_r   <= '0;
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
            tdata_r  <= tdata_nxt_s;
            tvalid_r <= tvalid_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            sent_r   <= sent_nxt_s;
        end
    end

    // Next-state and next-output computation for the table walker.
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        cnt_nxt_s    = cnt_r;
        tdata_nxt_s  = tdata_r;
        tvalid_nxt_s = tvalid_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        sent_nxt_s   = sent_r;
        advance_s    = 1'b0;
        finish_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    ptr_nxt_s   = '0;
                    sent_nxt_s  = '0;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_nxt_s = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_end_f(rdata_r)) begin
                    finish_s = 1'b1;
                end else if (is_delay_f(rdata_r)) begin
                    if (rdata_r[7:0] == 8'h00) begin
                        advance_s = 1'b1;
                    end else begin
                        cnt_nxt_s   = delay_load_s;
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    tdata_nxt_s  = rdata_r;
                    tvalid_nxt_s = 1'b1;
                    state_nxt_s  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis.m_axis_tready) begin
                    tvalid_nxt_s = 1'b0;
                    sent_nxt_s   = sent_r + SW'(1'b1);
                    advance_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                // Leave on the cycle the counter reaches its last tick so
                // exactly N*DELAY_UNIT cycles are spent here.
                cnt_nxt_s = cnt_r - CW'(1'b1);
                if (cnt_r <= CW'(1'b1)) begin
                    advance_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                tvalid_nxt_s = 1'b0;
                busy_nxt_s   = 1'b0;
            end
        endcase

        // Last table slot ends the run; the pointer never wraps.
        if (advance_s) begin
            if (ptr_r == AW'(TABLE_DEPTH - 1)) begin
                finish_s = 1'b1;
            end else begin
                ptr_nxt_s   = ptr_r + AW'(1'b1);
                state_nxt_s = ST_READ;
            end
        end else begin
            ptr_nxt_s = ptr_nxt_s;
        end

        if (finish_s) begin
            state_nxt_s = ST_IDLE;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    assign busy_o               = busy_r;
    assign done_o               = done_r;
    assign sent_cnt_o           = sent_r;
    assign m_axis.m_axis_tdata  = tdata_r;
    assign m_axis.m_axis_tvalid = tvalid_r;
endmodule

// File: tb/tb_axis_i2c_cmd_seq.sv
// Directed bench for the I2C command sequencer. Uses a 4-entry table and a
// 4-cycle delay unit so both the implicit end and delay timing are visible.
module tb_axis_i2c_cmd_seq;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int UNIT  = 4;

    logic        clk;
    logic        rst_i;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  sent;

    int pass_cnt;
    int total_cnt;

    axis_i2c_cmd_seq_if #(.DATA_WIDTH(DW)) m_axis_bus ();

    axis_i2c_cmd_seq #(
        .DATA_WIDTH (DW),
        .TABLE_DEPTH(DEPTH),
        .DELAY_UNIT (UNIT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .cfg_we_i   (cfg_we),
        .cfg_addr_i (cfg_addr),
        .cfg_wdata_i(cfg_wdata),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .sent_cnt_o (sent),
        .m_axis     (m_axis_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // Returns just after the start-sampling edge (edge 0).
    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start = 1'b1;
        tick();
        rst_i = 1'b0; start = 1'b0;
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata, busy, done, sent} !== 22'd0)
            $display("FAIL reset_outputs: got tv=%0b td=%h busy=%0b done=%0b sent=%0d want all 0",
                     m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata, busy, done, sent);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_start_ignored: busy=%0b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        load(2'd0, 16'h3412); load(2'd1, 16'h5678); load(2'd2, 16'hFFFF);
        m_axis_bus.m_axis_tready = 1'b1;
        start_pulse();
        total_cnt++;
        if ({busy, m_axis_bus.m_axis_tvalid} !== 2'b10)
            $display("FAIL basic_edge0: busy=%0b tv=%0b want busy=1 tv=0", busy, m_axis_bus.m_axis_tvalid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (m_axis_bus.m_axis_tvalid !== 1'b0) $display("FAIL basic_edge1_tvalid: got %0b want 0", m_axis_bus.m_axis_tvalid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata} !== {1'b1, 16'h3412})
            $display("FAIL basic_beat0: tv=%0b td=%h want 1/3412", m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, sent} !== {1'b0, 3'd1})
            $display("FAIL basic_hs0: tv=%0b sent=%0d want 0/1", m_axis_bus.m_axis_tvalid, sent);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (m_axis_bus.m_axis_tvalid !== 1'b0) $display("FAIL basic_gap: tv=%0b want 0", m_axis_bus.m_axis_tvalid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata} !== {1'b1, 16'h5678})
            $display("FAIL basic_beat1: tv=%0b td=%h want 1/5678", m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (sent !== 3'd2) $display("FAIL basic_hs1: sent=%0d want 2", sent);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, busy} !== 2'b01) $display("FAIL basic_pre_done: done=%0b busy=%0b want 0/1", done, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, busy, sent} !== {1'b1, 1'b0, 3'd2})
            $display("FAIL basic_done: done=%0b busy=%0b sent=%0d want 1/0/2", done, busy, sent);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse: done=%0b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        m_axis_bus.m_axis_tready = 1'b0;
        start_pulse();
        total_cnt++;
        if (sent !== 3'd0) $display("FAIL bp_sent_clear: sent=%0d want 0", sent);
        else pass_cnt++;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata, sent} !== {1'b1, 16'h3412, 3'd0})
                $display("FAIL bp_hold%0d: tv=%0b td=%h sent=%0d want 1/3412/0", i,
                         m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata, sent);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata} !== {1'b1, 16'h3412})
            $display("FAIL bp_hold_last: tv=%0b td=%h want 1/3412", m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata);
        else pass_cnt++;
        m_axis_bus.m_axis_tready = 1'b1;
        tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, sent} !== {1'b0, 3'd1})
            $display("FAIL bp_hs0: tv=%0b sent=%0d want 0/1", m_axis_bus.m_axis_tvalid, sent);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata} !== {1'b1, 16'h5678})
            $display("FAIL bp_beat1: tv=%0b td=%h want 1/5678", m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata);
        else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++;
        if ({done, busy, sent} !== {1'b1, 1'b0, 3'd2})
            $display("FAIL bp_done: done=%0b busy=%0b sent=%0d want 1/0/2", done, busy, sent);
        else pass_cnt++;
    endtask

    task automatic test_delay();
        load(2'd0, 16'h1111); load(2'd1, 16'hFF03); load(2'd2, 16'h2222); load(2'd3, 16'hFFFF);
        m_axis_bus.m_axis_tready = 1'b1;
        start_pulse();
        tick(); tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata} !== {1'b1, 16'h1111})
            $display("FAIL delay_beat0: tv=%0b td=%h want 1/1111", m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata);
        else pass_cnt++;
        tick();  // handshake edge h = 3
        for (int e = 4; e <= 18; e++) begin
            tick();
            total_cnt++;
            if ({m_axis_bus.m_axis_tvalid, busy} !== 2'b01)
                $display("FAIL delay_gap_edge%0d: tv=%0b busy=%0b want 0/1", e, m_axis_bus.m_axis_tvalid, busy);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata} !== {1'b1, 16'h2222})
            $display("FAIL delay_beat1: tv=%0b td=%h want 1/2222", m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata);
        else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++;
        if ({done, sent} !== {1'b1, 3'd2}) $display("FAIL delay_done: done=%0b sent=%0d want 1/2", done, sent);
        else pass_cnt++;
    endtask

    task automatic test_implicit_end();
        load(2'd0, 16'h0001); load(2'd1, 16'h0002); load(2'd2, 16'h0003); load(2'd3, 16'h0004);
        m_axis_bus.m_axis_tready = 1'b1;
        start_pulse();
        for (int i = 0; i < 4; i++) begin
            tick(); tick();
            total_cnt++;
            if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata} !== {1'b1, 16'(i + 1)})
                $display("FAIL impl_beat%0d: tv=%0b td=%h want 1/%h", i,
                         m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata, 16'(i + 1));
            else pass_cnt++;
            tick();
            total_cnt++;
            if (sent !== 3'(i + 1)) $display("FAIL impl_sent%0d: sent=%0d want %0d", i, sent, i + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if ({done, busy} !== 2'b10) $display("FAIL impl_done: done=%0b busy=%0b want 1/0", done, busy);
        else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++;
        if ({done, busy, m_axis_bus.m_axis_tvalid, sent} !== {3'b000, 3'd4})
            $display("FAIL impl_no_wrap: done=%0b busy=%0b tv=%0b sent=%0d want 0/0/0/4",
                     done, busy, m_axis_bus.m_axis_tvalid, sent);
        else pass_cnt++;
    endtask

    task automatic test_end_and_skip();
        load(2'd0, 16'hFFFF);
        start_pulse();
        tick(); tick();
        total_cnt++;
        if ({done, busy, m_axis_bus.m_axis_tvalid, sent} !== {3'b100, 3'd0})
            $display("FAIL end_first: done=%0b busy=%0b tv=%0b sent=%0d want 1/0/0/0",
                     done, busy, m_axis_bus.m_axis_tvalid, sent);
        else pass_cnt++;
        load(2'd0, 16'hFF00); load(2'd1, 16'hABCD); load(2'd2, 16'hFFFF);
        m_axis_bus.m_axis_tready = 1'b1;
        start_pulse();
        tick(); tick(); tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, busy} !== 2'b01)
            $display("FAIL skip_gap: tv=%0b busy=%0b want 0/1", m_axis_bus.m_axis_tvalid, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata} !== {1'b1, 16'hABCD})
            $display("FAIL skip_beat: tv=%0b td=%h want 1/abcd", m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata);
        else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++;
        if ({done, sent} !== {1'b1, 3'd1}) $display("FAIL skip_done: done=%0b sent=%0d want 1/1", done, sent);
        else pass_cnt++;
    endtask

    task automatic test_busy_and_reset();
        load(2'd0, 16'h3412); load(2'd1, 16'h5678); load(2'd2, 16'hFFFF);
        m_axis_bus.m_axis_tready = 1'b1;
        start_pulse();
        tick(); tick();
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'h0BAD; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        total_cnt++;
        if (sent !== 3'd1) $display("FAIL busy_hs0: sent=%0d want 1", sent);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata, sent} !== {1'b1, 16'h5678, 3'd1})
            $display("FAIL busy_start_ignored: tv=%0b td=%h sent=%0d want 1/5678/1",
                     m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata, sent);
        else pass_cnt++;
        m_axis_bus.m_axis_tready = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata, busy, done, sent} !== 22'd0)
            $display("FAIL midrun_reset: tv=%0b td=%h busy=%0b done=%0b sent=%0d want all 0",
                     m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata, busy, done, sent);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({busy, m_axis_bus.m_axis_tvalid} !== 2'b00)
            $display("FAIL midrun_idle: busy=%0b tv=%0b want 0/0", busy, m_axis_bus.m_axis_tvalid);
        else pass_cnt++;
        m_axis_bus.m_axis_tready = 1'b1;
        start_pulse();
        tick(); tick();
        total_cnt++;
        if ({m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata} !== {1'b1, 16'h3412})
            $display("FAIL busy_write_dropped: tv=%0b td=%h want 1/3412", m_axis_bus.m_axis_tvalid, m_axis_bus.m_axis_tdata);
        else pass_cnt++;
        tick(); tick(); tick(); tick(); tick(); tick();
        total_cnt++;
        if ({done, sent} !== {1'b1, 3'd2}) $display("FAIL rerun_done: done=%0b sent=%0d want 1/2", done, sent);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst_i = 1'b1;
        start = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = 2'd0;
        cfg_wdata = 16'h0000;
        m_axis_bus.m_axis_tready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_delay();
        test_implicit_end();
        test_end_and_skip();
        test_busy_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/axis_i2c_cmd_seq.md
Name: axis_i2c_cmd_seq

Overview:
- Programmable command sequencer that sits directly upstream of the AXI-Stream I2C top level.
- Holds a table of 16-bit I2C command words, loaded through a simple write port.
- On start, walks the table and emits each command as an AXI-Stream beat into the I2C path's input FIFO.
- Supports in-table delay entries (device power-up and settling times) and an end-of-table marker.
- Typical use: sensor/codec register initialisation after reset.

Parameters:
- DATA_WIDTH, 16: command word width; must be >= 16. The top 8 bits act as opcode field, the low 8 bits as argument.
- TABLE_DEPTH, 32: number of table entries; power of 2, >= 2.
- DELAY_UNIT, 1000: clk_i cycles per delay tick.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: synchronous reset, active-high.
- cfg_we_i, input, 1: table write enable.
- cfg_addr_i, input, $clog2(TABLE_DEPTH): table write address.
- cfg_wdata_i, input, DATA_WIDTH: table write data.
- start_i, input, 1: start sequence (sampled in IDLE only).
- busy_o, output, 1: sequence in progress.
- done_o, output, 1: one-cycle pulse at sequence end.
- sent_cnt_o, output, $clog2(TABLE_DEPTH+1): beats accepted downstream in the current/last run.
- m_axis_tdata, output, DATA_WIDTH: command word.
- m_axis_tvalid, output, 1: beat valid.
- m_axis_tready, input, 1: downstream ready.

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state=IDLE, ptr=0, m_axis_tvalid=0, m_axis_tdata=0, busy_o=0, done_o=0, sent_cnt_o=0, delay counter=0.
  - Table RAM is not reset.
  - Reset mid-run aborts at that edge; tvalid may drop without a handshake.
- Table: single-port-write, synchronous-read RAM; one-cycle read latency.
  - cfg_we_i is honoured only while busy_o=0; writes while busy are dropped.
- Entry decode for word w:
  - END: w == all ones.
  - DELAY: w[DW-1:DW-8] == 8'hFF and not END; ticks N = w[7:0].
  - DATA: anything else.
- States: IDLE, READ, DECODE, SEND, WAIT. All outputs are registered.
- IDLE:
  - done_o=0 except for the pulse cycle.
  - start_i=1 -> ptr<=0, sent_cnt_o<=0, busy_o<=1, go to READ.
- READ: RAM address = ptr; go to DECODE.
- DECODE:
  - END -> finish.
  - DELAY with N=0 -> advance.
  - DELAY with N>0 -> load counter with N*DELAY_UNIT, go to WAIT. Counter width is 8+$clog2(DELAY_UNIT+1); no overflow allowed.
  - DATA -> m_axis_tdata<=w, m_axis_tvalid<=1, go to SEND.
- SEND:
  - tdata/tvalid held stable while tready=0.
  - On tvalid&&tready: tvalid<=0, sent_cnt_o<=sent_cnt_o+1, advance.
- WAIT: counter decrements each cycle. Exactly N*DELAY_UNIT cycles are spent in WAIT, then advance.
- advance:
  - If ptr == TABLE_DEPTH-1 -> finish (implicit end, no wrap).
  - Otherwise ptr<=ptr+1, go to READ.
- finish: state<=IDLE, busy_o<=0, done_o<=1 for exactly one cycle.
- start_i while busy is ignored. start_i on the same edge as rst_i is ignored.
- Timing, with the start_i-sampling edge = edge 0:
  - First tvalid=1 after edge 2.
  - After a handshake at edge h, the next DATA beat has tvalid=1 after edge h+2, i.e. tvalid is low for exactly 2 cycles.
  - Throughput: at most 1 beat per 3 cycles.

Test Plan:
1. Load [0x3412, 0x5678, 0xFFFF], pulse start_i, tready=1 -> beats 0x3412 then 0x5678; first tvalid after edge 2; done_o one cycle; sent_cnt_o=2; busy_o=0 after done.
2. Same table, tready=0 for 5 cycles after first tvalid -> tdata held 0x3412, tvalid held high, no beat lost or duplicated; sent_cnt_o=2 at end.
3. DELAY_UNIT=4, table [0x1111, 0xFF03, 0x2222, 0xFFFF] -> exactly 12 cycles in WAIT; tvalid for 0x2222 rises after edge h+16, where h is the 0x1111 handshake edge.
4. TABLE_DEPTH=4, table [1,2,3,4] with no END entry -> 4 beats, implicit finish, done_o pulse, sent_cnt_o=4, no wrap to entry 0.
5. Table entry 0 = 0xFFFF -> zero beats; done_o high after edge 2; sent_cnt_o=0. An 0xFF00 entry -> skipped with no WAIT cycles.
6. While busy: start_i pulse and cfg_we_i to address 0 -> both ignored. Next, assert rst_i during SEND -> next cycle tvalid=0, busy_o=0, sent_cnt_o=0, state IDLE.
